// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter unit.
// Holds the PCU state encoding, increment and alignment helper.
package pc_gen_pkg;

    localparam int ISA_WIDTH       = 32;
    localparam int PCU_STATE_WIDTH = 2;
    localparam int PCU_INC         = 4;

    typedef enum logic [PCU_STATE_WIDTH-1:0] {
        PCU_IDLE  = 2'd0,
        PCU_ISSUE = 2'd1,
        PCU_EXEC  = 2'd2,
        PCU_HALT  = 2'd3
    } pcu_state_t;

    // IALIGN=16 only requires halfword alignment
    function automatic logic misaligned(
        input logic [1:0] lsb,
        input int         ialign
    );
        return (ialign == 16) ? lsb[0] : (|lsb);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// IFU fetch handshake, EXU completion, CSR redirect and status bundle
// shared between the PC unit (master) and its neighbours (slave).
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = ISA_WIDTH,
    parameter int CNT_WIDTH = 64
) ();

    logic [XLEN-1:0]      pc;
    logic                 pc_valid;
    logic                 pc_ready;
    logic                 ex_valid;
    logic                 ex_taken;
    logic                 ex_is_jalr;
    logic [XLEN-1:0]      ex_target;
    logic                 ex_halt;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic                 misalign;
    logic [XLEN-1:0]      misalign_addr;
    logic                 halted;
    logic [CNT_WIDTH-1:0] retire_cnt;

    modport master (
        output pc, pc_valid, misalign, misalign_addr,
        output halted, retire_cnt,
        input  pc_ready, ex_valid, ex_taken, ex_is_jalr,
        input  ex_target, ex_halt, redirect_valid, redirect_pc
    );

    modport slave (
        input  pc, pc_valid, misalign, misalign_addr,
        input  halted, retire_cnt,
        output pc_ready, ex_valid, ex_taken, ex_is_jalr,
        output ex_target, ex_halt, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/pc_gen_adder.sv
// Ripple-agnostic N-bit adder with carry in/out, used for pc + 4.
// Width is set by data_len.
module pc_gen_adder #(
    parameter int data_len = 32
) (
    input  logic [data_len-1:0] a,
    input  logic [data_len-1:0] b,
    input  logic                cin,
    output logic [data_len-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b}
                       + {{data_len{1'b0}}, cin};

endmodule

// File: rtl/pc_gen.sv
// Stateful PC unit: owns the PC, issues it to the IFU, waits for the
// EXU, selects the next PC, checks alignment, counts retirements.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = ISA_WIDTH,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h8000_0000),
    parameter int              IALIGN    = 32,
    parameter int              CNT_WIDTH = 64
) (
    input logic      clk,
    input logic      rst,
    pc_gen_if.master bus
);

    pcu_state_t      state;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] jump_pc;
    logic [XLEN-1:0] target;
    logic            target_bad;
    logic            unused_cout;

    pc_gen_adder #(
        .data_len(XLEN)
    ) u_inc (
        .a    (bus.pc),
        .b    (XLEN'(PCU_INC)),
        .cin  (1'b0),
        .sum  (pc_inc),
        .cout (unused_cout)
    );

    assign redir_pc = bus.redirect_pc & ~XLEN'(1);
    assign jump_pc  = bus.ex_is_jalr
                    ? (bus.ex_target & ~XLEN'(1))
                    : bus.ex_target;
    assign target   = bus.ex_taken ? jump_pc : pc_inc;
    assign target_bad = misaligned(target[1:0], IALIGN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= PCU_IDLE;
            bus.pc            <= RESET_VEC;
            bus.pc_valid      <= 1'b0;
            bus.misalign      <= 1'b0;
            bus.misalign_addr <= '0;
            bus.halted        <= 1'b0;
            bus.retire_cnt    <= '0;
        end else begin
            bus.misalign <= 1'b0;
            unique case (state)
                PCU_IDLE: begin
                    state        <= PCU_ISSUE;
                    bus.pc_valid <= 1'b1;
                end
                PCU_ISSUE: begin
                    // a redirect discards a same-cycle handshake
                    if (bus.redirect_valid) begin
                        bus.pc <= redir_pc;
                    end else if (bus.pc_ready) begin
                        state        <= PCU_EXEC;
                        bus.pc_valid <= 1'b0;
                    end
                end
                PCU_EXEC: begin
                    if (bus.ex_valid) begin
                        bus.retire_cnt <= bus.retire_cnt
                                        + CNT_WIDTH'(1);
                    end
                    if (bus.redirect_valid) begin
                        bus.pc       <= redir_pc;
                        state        <= PCU_ISSUE;
                        bus.pc_valid <= 1'b1;
                    end else if (bus.ex_valid) begin
                        if (bus.ex_halt) begin
                            state      <= PCU_HALT;
                            bus.halted <= 1'b1;
                        end else if (target_bad) begin
                            bus.misalign      <= 1'b1;
                            bus.misalign_addr <= target;
                        end else begin
                            bus.pc       <= target;
                            state        <= PCU_ISSUE;
                            bus.pc_valid <= 1'b1;
                        end
                    end
                end
                PCU_HALT: begin
                    state <= PCU_HALT;
                end
                default: begin
                    state <= PCU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector tables on two
// configurations plus randomized traffic against a reference model.
module tb_pc_gen;
    import pc_gen_pkg::*;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        exv;
        logic        taken;
        logic        jalr;
        logic        halt;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic        valid;
        logic        mis;
        logic [31:0] maddr;
        logic        halted;
        logic [63:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .CNT_WIDTH(64)) bus_a ();
    pc_gen_if #(.XLEN(32), .CNT_WIDTH(2))  bus_b ();

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'h8000_0000),
        .IALIGN(32), .CNT_WIDTH(64)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'hFFFF_FFF8),
        .IALIGN(16), .CNT_WIDTH(2)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    task automatic drive_a(input vec_t v);
        rst_a                = v.rst;
        bus_a.pc_ready       = v.ready;
        bus_a.ex_valid       = v.exv;
        bus_a.ex_taken       = v.taken;
        bus_a.ex_is_jalr     = v.jalr;
        bus_a.ex_halt        = v.halt;
        bus_a.ex_target      = v.tgt;
        bus_a.redirect_valid = v.redir;
        bus_a.redirect_pc    = v.rpc;
    endtask

    task automatic drive_b(input vec_t v);
        rst_b                = v.rst;
        bus_b.pc_ready       = v.ready;
        bus_b.ex_valid       = v.exv;
        bus_b.ex_taken       = v.taken;
        bus_b.ex_is_jalr     = v.jalr;
        bus_b.ex_halt        = v.halt;
        bus_b.ex_target      = v.tgt;
        bus_b.redirect_valid = v.redir;
        bus_b.redirect_pc    = v.rpc;
    endtask

    task automatic check(
        input string       name,
        input logic [31:0] g_pc,
        input logic        g_v,
        input logic        g_m,
        input logic [31:0] g_ma,
        input logic        g_h,
        input logic [63:0] g_c,
        input vec_t        e
    );
        n_tests++;
        if (g_pc !== e.pc || g_v !== e.valid || g_m !== e.mis ||
            g_ma !== e.maddr || g_h !== e.halted || g_c !== e.cnt) begin
            n_fail++;
            $display("FAIL %s: got pc=%h v=%b mis=%b ma=%h h=%b cnt=%0d",
                     name, g_pc, g_v, g_m, g_ma, g_h, g_c);
            $display("     %s: want pc=%h v=%b mis=%b ma=%h h=%b cnt=%0d",
                     name, e.pc, e.valid, e.mis, e.maddr, e.halted, e.cnt);
        end
    endtask

    // reference model for dut_a: phase 0 reset, 1 fetch, 2 exec, 3 stop
    int          m_ph;
    logic [31:0] m_pc;
    logic [31:0] m_ma;
    logic        m_mis;
    logic [63:0] m_cnt;

    task automatic model_step(input vec_t v);
        longint unsigned t;
        m_mis = 1'b0;
        if (v.rst) begin
            m_ph  = 0;
            m_pc  = 32'h8000_0000;
            m_ma  = 0;
            m_cnt = 0;
            return;
        end
        case (m_ph)
            0: m_ph = 1;
            1: begin
                if (v.redir) m_pc = v.rpc - (v.rpc % 2);
                else if (v.ready) m_ph = 2;
            end
            2: begin
                if (v.exv) m_cnt = m_cnt + 1;
                if (v.redir) begin
                    m_pc = v.rpc - (v.rpc % 2);
                    m_ph = 1;
                end else if (v.exv && v.halt) begin
                    m_ph = 3;
                end else if (v.exv) begin
                    if (v.taken)
                        t = v.jalr ? v.tgt - (v.tgt % 2) : v.tgt;
                    else
                        t = (longint'(m_pc) + 4) % 64'h1_0000_0000;
                    if (t % 4 != 0) begin
                        m_mis = 1'b1;
                        m_ma  = 32'(t);
                    end else begin
                        m_pc = 32'(t);
                        m_ph = 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    vec_t ta[$];
    vec_t tb[$];
    vec_t idle_v;

    initial begin
        vec_t v;
        vec_t e;
        idle_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive_a(idle_v);
        drive_b(idle_v);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // dut_a: rst,rdy,exv,tkn,jalr,halt,redir,tgt,rpc | pc,v,mis,ma,h,cnt
        ta.push_back('{1,0,0,0,0,0,0,0,0, 32'h8000_0000,0,0,0,0,0});
        ta.push_back('{0,0,0,0,0,0,0,0,0, 32'h8000_0000,1,0,0,0,0});
        ta.push_back('{0,1,0,0,0,0,0,0,0, 32'h8000_0000,0,0,0,0,0});
        ta.push_back('{0,0,1,0,0,0,0,0,0, 32'h8000_0004,1,0,0,0,1});
        ta.push_back('{0,1,0,0,0,0,0,0,0, 32'h8000_0004,0,0,0,0,1});
        ta.push_back('{0,0,1,0,0,0,0,0,0, 32'h8000_0008,1,0,0,0,2});
        ta.push_back('{0,1,0,0,0,0,0,0,0, 32'h8000_0008,0,0,0,0,2});
        ta.push_back('{0,0,1,0,0,0,0,0,0, 32'h8000_000C,1,0,0,0,3});
        ta.push_back('{0,1,0,0,0,0,0,0,0, 32'h8000_000C,0,0,0,0,3});
        ta.push_back('{0,0,1,1,1,0,0,32'h8000_0101,0,
                       32'h8000_0100,1,0,0,0,4});
        ta.push_back('{0,1,0,0,0,0,0,0,0, 32'h8000_0100,0,0,0,0,4});
        ta.push_back('{0,0,1,1,0,0,0,32'h8000_0102,0,
                       32'h8000_0100,0,1,32'h8000_0102,0,5});
        ta.push_back('{0,0,0,0,0,0,0,0,0,
                       32'h8000_0100,0,0,32'h8000_0102,0,5});
        ta.push_back('{0,0,0,0,0,0,1,0,32'h8000_1000,
                       32'h8000_1000,1,0,32'h8000_0102,0,5});
        for (int i = 0; i < 5; i++)
            ta.push_back('{0,0,0,0,0,0,0,0,0,
                           32'h8000_1000,1,0,32'h8000_0102,0,5});
        ta.push_back('{0,1,0,0,0,0,1,0,32'h8000_2001,
                       32'h8000_2000,1,0,32'h8000_0102,0,5});
        ta.push_back('{0,1,0,0,0,0,0,0,0,
                       32'h8000_2000,0,0,32'h8000_0102,0,5});
        ta.push_back('{0,0,1,1,0,0,1,32'h8000_0006,32'h8000_3000,
                       32'h8000_3000,1,0,32'h8000_0102,0,6});
        ta.push_back('{0,1,0,0,0,0,0,0,0,
                       32'h8000_3000,0,0,32'h8000_0102,0,6});
        ta.push_back('{0,0,1,0,0,1,0,0,0,
                       32'h8000_3000,0,0,32'h8000_0102,1,7});
        ta.push_back('{0,1,0,0,0,0,1,0,32'h8000_4000,
                       32'h8000_3000,0,0,32'h8000_0102,1,7});
        ta.push_back('{1,0,0,0,0,0,0,0,0, 32'h8000_0000,0,0,0,0,0});
        ta.push_back('{0,0,0,0,0,0,0,0,0, 32'h8000_0000,1,0,0,0,0});

        // dut_b: RESET_VEC=FFFF_FFF8, IALIGN=16, 2-bit counter
        tb.push_back('{1,0,0,0,0,0,0,0,0, 32'hFFFF_FFF8,0,0,0,0,0});
        tb.push_back('{0,0,0,0,0,0,0,0,0, 32'hFFFF_FFF8,1,0,0,0,0});
        tb.push_back('{0,1,0,0,0,0,0,0,0, 32'hFFFF_FFF8,0,0,0,0,0});
        tb.push_back('{0,0,1,0,0,0,0,0,0, 32'hFFFF_FFFC,1,0,0,0,1});
        tb.push_back('{0,1,0,0,0,0,0,0,0, 32'hFFFF_FFFC,0,0,0,0,1});
        tb.push_back('{0,0,1,0,0,0,0,0,0, 32'h0000_0000,1,0,0,0,2});
        tb.push_back('{0,1,0,0,0,0,0,0,0, 32'h0000_0000,0,0,0,0,2});
        tb.push_back('{0,0,1,0,0,0,0,0,0, 32'h0000_0004,1,0,0,0,3});
        tb.push_back('{0,1,0,0,0,0,0,0,0, 32'h0000_0004,0,0,0,0,3});
        tb.push_back('{0,0,1,1,0,0,0,32'h0000_0102,0,
                       32'h0000_0102,1,0,0,0,0});
        tb.push_back('{0,1,0,0,0,0,0,0,0, 32'h0000_0102,0,0,0,0,0});
        tb.push_back('{0,0,1,1,0,0,0,32'h0000_0205,0,
                       32'h0000_0102,0,1,32'h0000_0205,0,1});
        tb.push_back('{0,0,0,0,0,0,1,0,32'h0000_0401,
                       32'h0000_0400,1,0,32'h0000_0205,0,1});

        @(negedge clk);
        foreach (ta[i]) begin
            drive_a(ta[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec_a[%0d]", i), bus_a.pc, bus_a.pc_valid,
                  bus_a.misalign, bus_a.misalign_addr, bus_a.halted,
                  bus_a.retire_cnt, ta[i]);
        end
        foreach (tb[i]) begin
            drive_b(tb[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec_b[%0d]", i), bus_b.pc, bus_b.pc_valid,
                  bus_b.misalign, bus_b.misalign_addr, bus_b.halted,
                  64'(bus_b.retire_cnt), tb[i]);
        end

        // randomized traffic on dut_a, starting from a reset
        m_ph = 0;
        for (int c = 0; c < 3000; c++) begin
            v = idle_v;
            v.rst   = (c == 0) || ($urandom_range(0, 59) == 0);
            v.ready = 1'($urandom_range(0, 1));
            v.redir = ($urandom_range(0, 7) == 0);
            v.rpc   = ($urandom_range(0, 3) == 0)
                    ? 32'hFFFF_FFFC : $urandom;
            v.exv   = (m_ph == 2) && ($urandom_range(0, 2) == 0);
            v.taken = 1'($urandom_range(0, 1));
            v.jalr  = 1'($urandom_range(0, 1));
            v.halt  = ($urandom_range(0, 39) == 0);
            v.tgt   = $urandom;
            if ($urandom_range(0, 3) != 0)
                v.tgt[1:0] = 2'b00;
            assert (!(v.exv && m_ph != 2));
            drive_a(v);
            @(posedge clk);
            model_step(v);
            #1;
            e = idle_v;
            e.pc     = m_pc;
            e.valid  = (m_ph == 1);
            e.mis    = m_mis;
            e.maddr  = m_ma;
            e.halted = (m_ph == 3);
            e.cnt    = m_cnt;
            check($sformatf("rand[%0d]", c), bus_a.pc, bus_a.pc_valid,
                  bus_a.misalign, bus_a.misalign_addr, bus_a.halted,
                  bus_a.retire_cnt, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
